// File: rtl/ppr_pkg.sv
// Shared types and constants for the encoder pulses-per-revolution checker.
// Holds the FSM encoding, the counter width and the default expected count.
package ppr_pkg;

    localparam int CNT_W   = 16;
    localparam int DEF_PPR = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge strobe.
// The strobe rises three clocks after the pin edge.
module sig_sync_edge (
    input  logic Clk,
    input  logic Rst_n,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            rise <= s2 & ~prev;
        end
    end

endmodule

// File: rtl/ppr_check.sv
// Counts encoder A edges between Z index edges and reports the count,
// a pass/fail verdict against the expected value, and an idle timeout.
module ppr_check
    import ppr_pkg::*;
#(
    parameter int EXPECTED_PPR = DEF_PPR,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Ain,
    input  logic             Zin,
    input  logic             Clear,
    output logic [CNT_W-1:0] PprCount,
    output logic             Valid,
    output logic             Pass,
    output logic             Fail,
    output logic             Timeout,
    output logic [1:0]       State
);

    localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXPECTED_PPR);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic a_e;
    logic z_e;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] ppr_q, ppr_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] tmr_inc;

    sig_sync_edge u_sync_a (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .din   (Ain),
        .rise  (a_e)
    );

    sig_sync_edge u_sync_z (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .din   (Zin),
        .rise  (z_e)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            ppr_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ppr_q   <= ppr_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        ppr_d   = ppr_q;
        valid_d = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        tmr_inc = timer_q + ONE_C;

        if (Clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            timer_d = '0;
            ppr_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            tmo_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    timer_d = '0;
                    if (a_e || z_e)
                        state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (z_e) begin
                        state_d = ST_MEAS;
                        cnt_d   = a_e ? ONE_C : '0;
                    end
                end
                ST_MEAS: begin
                    if (z_e) begin
                        // A coincident A edge belongs to the new revolution
                        ppr_d   = cnt_q;
                        pass_d  = (cnt_q == EXP_C);
                        fail_d  = (cnt_q != EXP_C);
                        valid_d = 1'b1;
                        cnt_d   = a_e ? ONE_C : '0;
                    end else if (a_e) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            endcase

            if (state_q == ST_ARM || state_q == ST_MEAS) begin
                if (a_e || z_e) begin
                    timer_d = '0;
                end else if (tmr_inc == TMO_C) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                    timer_d = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = tmr_inc;
                end
            end
        end
    end

    assign PprCount = ppr_q;
    assign Valid    = valid_q;
    assign Pass     = pass_q;
    assign Fail     = fail_q;
    assign Timeout  = tmo_q;
    assign State    = state_q;

endmodule

// File: tb/tb_ppr_check.sv
// Directed-plus-random bench for ppr_check with a small revolution model.
// Uses a short expected count and timeout to keep runs brief.
module tb_ppr_check;

    localparam int PPR = 64;
    localparam int TMO = 100;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Ain = 1'b0;
    logic        Zin = 1'b0;
    logic        Clear = 1'b0;
    logic [15:0] PprCount;
    logic        Valid;
    logic        Pass;
    logic        Fail;
    logic        Timeout;
    logic [1:0]  State;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int exp_v = 0;
    int carry = 0;
    int exp_ppr = 0;

    ppr_check #(
        .EXPECTED_PPR (PPR),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Ain      (Ain),
        .Zin      (Zin),
        .Clear    (Clear),
        .PprCount (PprCount),
        .Valid    (Valid),
        .Pass     (Pass),
        .Fail     (Fail),
        .Timeout  (Timeout),
        .State    (State)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Valid) vcnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic a_pulse();
        Ain = 1'b1;
        clocks($urandom_range(2, 5));
        Ain = 1'b0;
        clocks($urandom_range(2, 5));
    endtask

    task automatic z_pulse(input bit with_a);
        Zin = 1'b1;
        if (with_a) Ain = 1'b1;
        clocks(3);
        Zin = 1'b0;
        Ain = 1'b0;
        clocks(3);
    endtask

    task automatic arm();
        z_pulse(1'b0);
        chk("arm_state", int'(State), 1);
        z_pulse(1'b0);
        chk("meas_state", int'(State), 2);
        chk("arm_novalid", vcnt, exp_v);
        carry = 0;
    endtask

    // A revolution closes with carry-in plus the A edges driven before Z.
    task automatic rev(input int n, input bit coinc);
        int c;
        repeat (n) a_pulse();
        z_pulse(coinc);
        clocks(3);
        c = carry + n;
        carry = coinc ? 1 : 0;
        exp_v++;
        exp_ppr = c;
        chk("valid_cnt", vcnt, exp_v);
        chk("ppr", int'(PprCount), c);
        chk("pass", int'(Pass), int'(c == PPR));
        chk("fail", int'(Fail), int'(c != PPR));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ppr"}, int'(PprCount), 0);
        chk({tag, "_pass"}, int'(Pass), 0);
        chk({tag, "_fail"}, int'(Fail), 0);
        chk({tag, "_tmo"}, int'(Timeout), 0);
        chk({tag, "_valid"}, int'(Valid), 0);
        chk({tag, "_state"}, int'(State), 0);
    endtask

    initial begin
        clocks(3);
        Rst_n = 1'b1;
        chk_zero("reset");
        clocks(2);

        arm();
        rev(PPR, 1'b0);
        rev(PPR - 1, 1'b0);
        rev(PPR, 1'b0);
        rev(PPR, 1'b1);
        rev(PPR, 1'b0);

        for (int i = 0; i < 4; i++)
            rev(PPR - 2 + int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

        repeat (10) a_pulse();
        clocks(40);
        chk("tmo_early", int'(Timeout), 0);
        clocks(80);
        chk("tmo_set", int'(Timeout), 1);
        chk("tmo_state", int'(State), 0);
        chk("tmo_ppr", int'(PprCount), exp_ppr);
        chk("tmo_novalid", vcnt, exp_v);

        arm();
        chk("tmo_sticky", int'(Timeout), 1);
        rev(PPR, 1'b0);

        repeat (20) a_pulse();
        Zin = 1'b1;
        clocks(3);
        Clear = 1'b1;
        clocks(1);
        Clear = 1'b0;
        Zin = 1'b0;
        clocks(4);
        chk("clr_novalid", vcnt, exp_v);
        chk_zero("clear");

        arm();
        repeat (30) a_pulse();
        Rst_n = 1'b0;
        clocks(1);
        Rst_n = 1'b1;
        chk_zero("midrst");
        clocks(4);
        chk("midrst_novalid", vcnt, exp_v);
        arm();
        rev(PPR, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
